// File: rtl/enemy_spawn_scheduler_if.sv
// rtl/enemy_spawn_scheduler_if.sv - kill-request handshake and slot read port of the spawn scheduler
// Signals:
//   hit_valid/hit_slot  -> kill request from bullet hit detection (held until hit_ready)
//   hit_ready           <- request accepted this cycle when high together with hit_valid
//   rd_slot             -> slot select for the VGA pixel mux
//   rd_x/rd_y/rd_active <- combinational view of the selected slot
// Modports: master = requester / pixel mux side, slave = scheduler side.
interface enemy_spawn_scheduler_if;
    logic       hit_valid;
    logic [1:0] hit_slot;
    logic       hit_ready;
    logic [1:0] rd_slot;
    logic [9:0] rd_x;
    logic [9:0] rd_y;
    logic       rd_active;

    modport master (
        output hit_valid, hit_slot, rd_slot,
        input  hit_ready, rd_x, rd_y, rd_active
    );

    modport slave (
        input  hit_valid, hit_slot, rd_slot,
        output hit_ready, rd_x, rd_y, rd_active
    );
endinterface

// File: rtl/enemy_spawn_scheduler.sv
// rtl/enemy_spawn_scheduler.sv - enemy slot table with LFSR-driven, frame-paced spawn scheduling
// Ports:
//   clk_25, rst       pixel clock, asynchronous active-high reset
//   frame_tick        one-cycle pulse per frame
//   enable            spawning allowed
//   player_x/y        player box top-left corner (spawns never overlap it)
//   bus               kill handshake and slot read port (slave side)
//   active_mask, full per-slot active flags, all slots active
//   spawn_pulse/slot  one-cycle pulse and slot index on each commit
//   kill_count        kills of active slots, saturating at 255
module enemy_spawn_scheduler #(
    parameter int          NUM_SLOTS      = 4,
    parameter int          SPAWN_INTERVAL = 60,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int          ENEMY_SIZE     = 20,
    parameter int          X_MAX          = 620,
    parameter int          Y_MAX          = 460
) (
    input  logic                   clk_25,
    input  logic                   rst,
    input  logic                   frame_tick,
    input  logic                   enable,
    input  logic [9:0]             player_x,
    input  logic [9:0]             player_y,
    enemy_spawn_scheduler_if.slave bus,
    output logic [NUM_SLOTS-1:0]   active_mask,
    output logic                   spawn_pulse,
    output logic [1:0]             spawn_slot,
    output logic [7:0]             kill_count,
    output logic                   full
);
    typedef enum logic [1:0] {IDLE, COUNT, PICK, COMMIT} state_t;

    localparam logic [7:0]  LAST_TICK = 8'(SPAWN_INTERVAL - 1);
    localparam logic [9:0]  X_LIMIT   = 10'(X_MAX);
    localparam logic [9:0]  Y_LIMIT   = 10'(Y_MAX);
    localparam logic [10:0] BOX       = 11'(ENEMY_SIZE);
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    state_t               state;
    logic [7:0]           timer;
    logic [15:0]          lfsr;
    logic [9:0]           slot_x [NUM_SLOTS];
    logic [9:0]           slot_y [NUM_SLOTS];
    logic [9:0]           pend_x;
    logic [9:0]           pend_y;
    logic [1:0]           pend_slot;

    logic [9:0]           x_raw;
    logic [9:0]           y_raw;
    logic [9:0]           cand_x;
    logic [9:0]           cand_y;
    logic                 overlap;
    logic                 free_found;
    logic [1:0]           free_idx;
    logic                 hit_accept;
    logic [NUM_SLOTS-1:0] mask_next;

    // Out-of-range raw values fold back by a power of two, which always lands inside the legal area.
    assign x_raw  = lfsr[9:0];
    assign y_raw  = {1'b0, lfsr[15:7]};
    assign cand_x = (x_raw > X_LIMIT) ? x_raw - 10'd512 : x_raw;
    assign cand_y = (y_raw > Y_LIMIT) ? y_raw - 10'd64  : y_raw;

    // Box intersection in 11 bits so coordinate + size cannot wrap.
    assign overlap = ({1'b0, cand_x} < {1'b0, player_x} + BOX) &&
                     ({1'b0, cand_x} + BOX > {1'b0, player_x}) &&
                     ({1'b0, cand_y} < {1'b0, player_y} + BOX) &&
                     ({1'b0, cand_y} + BOX > {1'b0, player_y});

    // Lowest-index inactive slot: scan downward so the lowest hit wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = 2'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!active_mask[i]) begin
                free_found = 1'b1;
                free_idx   = 2'(i);
            end
        end
    end

    assign hit_accept = bus.hit_valid && bus.hit_ready;

    // hit_ready is low in COMMIT, so a kill and a commit never touch the mask in the same cycle.
    always_comb begin
        mask_next = active_mask;
        if (hit_accept) begin
            mask_next[bus.hit_slot] = 1'b0;
        end
        if (state == COMMIT) begin
            mask_next[pend_slot] = 1'b1;
        end
    end

    assign bus.rd_x      = slot_x[bus.rd_slot];
    assign bus.rd_y      = slot_y[bus.rd_slot];
    assign bus.rd_active = active_mask[bus.rd_slot];

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            timer         <= 8'd0;
            lfsr          <= LFSR_SEED;
            active_mask   <= '0;
            full          <= 1'b0;
            spawn_pulse   <= 1'b0;
            spawn_slot    <= 2'd0;
            kill_count    <= 8'd0;
            bus.hit_ready <= 1'b1;
            pend_x        <= 10'd0;
            pend_y        <= 10'd0;
            pend_slot     <= 2'd0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_x[i] <= 10'd0;
                slot_y[i] <= 10'd0;
            end
        end else begin
            lfsr          <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
            active_mask   <= mask_next;
            full          <= &mask_next;
            spawn_pulse   <= 1'b0;
            bus.hit_ready <= 1'b1;

            if (hit_accept && active_mask[bus.hit_slot] && kill_count != 8'hFF) begin
                kill_count <= kill_count + 8'd1;
            end

            case (state)
                IDLE: begin
                    timer <= 8'd0;
                    if (enable) begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (!enable) begin
                        state <= IDLE;
                        timer <= 8'd0;
                    end else if (frame_tick) begin
                        // timer stays at LAST_TICK so a failed attempt retries on the next tick
                        if (timer == LAST_TICK) begin
                            state <= PICK;
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end
                end
                PICK: begin
                    if (!enable) begin
                        state <= IDLE;
                        timer <= 8'd0;
                    end else if (!free_found || overlap) begin
                        state <= COUNT;
                    end else begin
                        pend_x        <= cand_x;
                        pend_y        <= cand_y;
                        pend_slot     <= free_idx;
                        spawn_pulse   <= 1'b1;
                        spawn_slot    <= free_idx;
                        bus.hit_ready <= 1'b0;
                        state         <= COMMIT;
                    end
                end
                COMMIT: begin
                    slot_x[pend_slot] <= pend_x;
                    slot_y[pend_slot] <= pend_y;
                    timer             <= 8'd0;
                    state             <= enable ? COUNT : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
